// File: rtl/decoded_bits_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : decoded_bits_sequencer
// Purpose  : Sequences the decoded-bits shift buffer for one polar frame.
//            Takes 2-bit hard decisions from the SCAN leaf stage and forces
//            frozen positions to 0. Issues one shift per accepted pair and
//            counts N/2 pairs. It then flags frame completion and holds the
//            buffer until the downstream consumer acknowledges.
// Ports    : clk                - system clock, rising edge
//            rst                - asynchronous reset, active low
//            I_start            - one-cycle frame start pulse
//            I_frozen_mask[N]   - 1 = frozen bit, latched on accepted start
//            I_leaf_valid       - leaf pair decision valid
//            I_leaf_bits[2]     - [0] = bit 2k, [1] = bit 2k+1 of pair k
//            I_out_ack          - downstream has consumed the buffer
//            O_hard_bit_out[2]  - masked pair to the buffer
//            O_output_bits_flag - buffer shift enable (one-cycle pulse)
//            O_pair_idx[CNT_W]  - index of the next expected pair
//            O_leaf_ready       - sequencer accepts leaf pairs
//            O_busy             - frame in progress
//            O_frame_done       - buffer holds a complete frame
//            O_err_overrun      - sticky protocol error
// Revision : 1.0 - initial release
// ============================================================================
module decoded_bits_sequencer #(
  parameter int N     = 1024,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             I_start,
  input  logic [N-1:0]     I_frozen_mask,
  input  logic             I_leaf_valid,
  input  logic [1:0]       I_leaf_bits,
  input  logic             I_out_ack,
  output logic [1:0]       O_hard_bit_out,
  output logic             O_output_bits_flag,
  output logic [CNT_W-1:0] O_pair_idx,
  output logic             O_leaf_ready,
  output logic             O_busy,
  output logic             O_frame_done,
  output logic             O_err_overrun
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FLUSH   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_LAST_PAIR = CNT_W'(N / 2 - 1);

  state_t           r_state, w_state_nxt;
  logic [N-1:0]     r_mask, w_mask_nxt;
  logic [CNT_W-1:0] r_pair_idx, w_pair_idx_nxt;
  logic [1:0]       r_hard, w_hard_nxt;
  logic             r_flag, w_flag_nxt;
  logic             r_ready, r_busy, r_done;
  logic             r_err, w_err_nxt;
  logic             w_start_ok;
  logic [1:0]       w_pair_mask;

  // Frozen flags of the pair currently expected: bits [2k+1:2k].
  assign w_pair_mask = r_mask[{r_pair_idx, 1'b0} +: 2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_mask     <= '0;
      r_pair_idx <= '0;
      r_hard     <= 2'b00;
      r_flag     <= 1'b0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mask     <= w_mask_nxt;
      r_pair_idx <= w_pair_idx_nxt;
      r_hard     <= w_hard_nxt;
      r_flag     <= w_flag_nxt;
      // Status outputs are decoded from the next state so they line up
      // with the state register rather than lagging it by a cycle.
      r_ready    <= (w_state_nxt == S_COLLECT);
      r_busy     <= (w_state_nxt == S_COLLECT) || (w_state_nxt == S_FLUSH);
      r_done     <= (w_state_nxt == S_DONE);
      r_err      <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_mask_nxt     = r_mask;
    w_pair_idx_nxt = r_pair_idx;
    w_hard_nxt     = r_hard;
    w_flag_nxt     = 1'b0;
    w_err_nxt      = r_err;
    w_start_ok     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (I_start) w_start_ok = 1'b1;
      end
      S_COLLECT: begin
        if (I_leaf_valid) begin
          w_flag_nxt     = 1'b1;
          w_hard_nxt     = I_leaf_bits & ~w_pair_mask;
          // Counter width is log2(N/2), so the last pair wraps to 0.
          w_pair_idx_nxt = r_pair_idx + 1'b1;
          if (r_pair_idx == c_LAST_PAIR) w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        // Ack together with start restarts immediately; start alone is
        // ignored so the finished frame stays frozen.
        if (I_out_ack) begin
          if (I_start) w_start_ok = 1'b1;
          else         w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_start_ok) begin
      w_state_nxt    = S_COLLECT;
      w_mask_nxt     = I_frozen_mask;
      w_pair_idx_nxt = '0;
      w_err_nxt      = 1'b0;
    end

    // Error sets are applied last so a stray event in the same cycle as
    // an accepted start is still reported.
    if (I_leaf_valid && (r_state != S_COLLECT)) w_err_nxt = 1'b1;
    if (I_start && ((r_state == S_COLLECT) || (r_state == S_FLUSH))) w_err_nxt = 1'b1;
  end

  assign O_hard_bit_out     = r_hard;
  assign O_output_bits_flag = r_flag;
  assign O_pair_idx         = r_pair_idx;
  assign O_leaf_ready       = r_ready;
  assign O_busy             = r_busy;
  assign O_frame_done       = r_done;
  assign O_err_overrun      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_decoded_bits_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoded_bits_sequencer
// Purpose  : Self-checking bench for decoded_bits_sequencer. A short vector
//            table covers the first cycles of a frame, and directed
//            sequences cover full frames and the multi-cycle corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoded_bits_sequencer;

  localparam int N     = 1024;
  localparam int CNT_W = 9;
  localparam int NP    = N / 2;

  logic             clk;
  logic             rst;
  logic             I_start;
  logic [N-1:0]     I_frozen_mask;
  logic             I_leaf_valid;
  logic [1:0]       I_leaf_bits;
  logic             I_out_ack;
  logic [1:0]       O_hard_bit_out;
  logic             O_output_bits_flag;
  logic [CNT_W-1:0] O_pair_idx;
  logic             O_leaf_ready;
  logic             O_busy;
  logic             O_frame_done;
  logic             O_err_overrun;

  decoded_bits_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .I_start            (I_start),
    .I_frozen_mask      (I_frozen_mask),
    .I_leaf_valid       (I_leaf_valid),
    .I_leaf_bits        (I_leaf_bits),
    .I_out_ack          (I_out_ack),
    .O_hard_bit_out     (O_hard_bit_out),
    .O_output_bits_flag (O_output_bits_flag),
    .O_pair_idx         (O_pair_idx),
    .O_leaf_ready       (O_leaf_ready),
    .O_busy             (O_busy),
    .O_frame_done       (O_frame_done),
    .O_err_overrun      (O_err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side copy of the downstream shift buffer: new pairs enter at the
  // top, so after N/2 shifts pair k sits at bits [2k+1:2k].
  logic [N-1:0] tb_buf;
  int           flag_cnt = 0;
  always @(posedge clk) begin
    if (O_output_bits_flag) begin
      tb_buf   <= {O_hard_bit_out, tb_buf[N-1:2]};
      flag_cnt <= flag_cnt + 1;
    end
  end

  int           n_checks = 0;
  int           n_errors = 0;
  logic [N-1:0] cur_mask;
  logic         err_exp;
  int           flag_base;
  logic [1:0]   exp_pair [NP];

  typedef struct {
    logic             start;
    logic             valid;
    logic [1:0]       bits;
    logic             ack;
    logic             e_flag;
    logic [1:0]       e_hard;
    logic [CNT_W-1:0] e_idx;
    logic             e_ready;
    logic             e_busy;
    logic             e_done;
    logic             e_err;
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mkvec(input logic s, input logic v, input logic [1:0] b,
                                 input logic a, input logic f, input logic [1:0] h,
                                 input int idx, input logic r, input logic bz,
                                 input logic d, input logic e);
    vec_t t;
    t.start = s; t.valid = v; t.bits = b; t.ack = a;
    t.e_flag = f; t.e_hard = h; t.e_idx = CNT_W'(idx);
    t.e_ready = r; t.e_busy = bz; t.e_done = d; t.e_err = e;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hard"},  32'(O_hard_bit_out), 0);
    chk({tag, "_flag"},  32'(O_output_bits_flag), 0);
    chk({tag, "_idx"},   32'(O_pair_idx), 0);
    chk({tag, "_ready"}, 32'(O_leaf_ready), 0);
    chk({tag, "_busy"},  32'(O_busy), 0);
    chk({tag, "_done"},  32'(O_frame_done), 0);
    chk({tag, "_err"},   32'(O_err_overrun), 0);
  endtask

  task automatic start_frame(input logic [N-1:0] mask);
    cur_mask      = mask;
    I_frozen_mask = mask;
    I_start       = 1'b1;
    tick();
    I_start   = 1'b0;
    err_exp   = 1'b0;
    flag_base = flag_cnt;
    chk("start_busy",  32'(O_busy), 1);
    chk("start_ready", 32'(O_leaf_ready), 1);
    chk("start_idx",   32'(O_pair_idx), 0);
    chk("start_err",   32'(O_err_overrun), 0);
    chk("start_done",  32'(O_frame_done), 0);
    chk("start_flag",  32'(O_output_bits_flag), 0);
  endtask

  // mode 0: bits {k[0],~k[0]} back-to-back; 1: bits 11 back-to-back;
  // 2: bits {k[0],~k[0]} with valid toggling 1010...
  task automatic feed_pairs(input int first, input int last, input int mode, input int start_at);
    for (int k = first; k <= last; k++) begin
      logic [1:0] b;
      logic [1:0] e;
      b = (mode == 1) ? 2'b11 : {k[0], ~k[0]};
      e = b & ~cur_mask[2*k +: 2];
      exp_pair[k]  = e;
      I_leaf_valid = 1'b1;
      I_leaf_bits  = b;
      I_start      = (k == start_at);
      if (k == start_at) err_exp = 1'b1;
      tick();
      I_leaf_valid = 1'b0;
      I_start      = 1'b0;
      chk($sformatf("pair%0d_flag", k),  32'(O_output_bits_flag), 1);
      chk($sformatf("pair%0d_hard", k),  32'(O_hard_bit_out), 32'(e));
      chk($sformatf("pair%0d_idx", k),   32'(O_pair_idx), 32'((k + 1) % NP));
      chk($sformatf("pair%0d_ready", k), 32'(O_leaf_ready), (k != NP - 1) ? 1 : 0);
      chk($sformatf("pair%0d_busy", k),  32'(O_busy), 1);
      chk($sformatf("pair%0d_done", k),  32'(O_frame_done), 0);
      chk($sformatf("pair%0d_err", k),   32'(O_err_overrun), 32'(err_exp));
      if (mode == 2 && k != NP - 1) begin
        tick();
        chk($sformatf("gap%0d_flag", k), 32'(O_output_bits_flag), 0);
        chk($sformatf("gap%0d_idx", k),  32'(O_pair_idx), 32'((k + 1) % NP));
        chk($sformatf("gap%0d_done", k), 32'(O_frame_done), 0);
      end
    end
  endtask

  task automatic finish_frame();
    int bad;
    I_leaf_valid = 1'b0;
    tick();
    chk("fin_done",  32'(O_frame_done), 1);
    chk("fin_busy",  32'(O_busy), 0);
    chk("fin_flag",  32'(O_output_bits_flag), 0);
    chk("fin_ready", 32'(O_leaf_ready), 0);
    chk("fin_idx",   32'(O_pair_idx), 0);
    chk("fin_err",   32'(O_err_overrun), 32'(err_exp));
    chk("fin_flag_count", 32'(flag_cnt - flag_base), NP);
    bad = 0;
    for (int k = 0; k < NP; k++)
      if (tb_buf[2*k +: 2] !== exp_pair[k]) bad++;
    chk("fin_buffer_pair_mismatches", 32'(bad), 0);
    tick();
    chk("hold_done", 32'(O_frame_done), 1);
    chk("hold_flag", 32'(O_output_bits_flag), 0);
  endtask

  task automatic ack_frame();
    I_out_ack = 1'b1;
    tick();
    I_out_ack = 1'b0;
    chk("ack_done",  32'(O_frame_done), 0);
    chk("ack_busy",  32'(O_busy), 0);
    chk("ack_ready", 32'(O_leaf_ready), 0);
  endtask

  initial begin
    rst           = 1'b0;
    I_start       = 1'b0;
    I_frozen_mask = '0;
    I_leaf_valid  = 1'b0;
    I_leaf_bits   = 2'b00;
    I_out_ack     = 1'b0;
    cur_mask      = '0;
    err_exp       = 1'b0;
    flag_base     = 0;

    // ---------------- reset state ----------------
    repeat (2) tick();
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    tick();

    // ---------------- vector table, mask bits 1 and 2 frozen ----------------
    //                 start valid bits  ack  flag hard  idx rdy busy done err
    vecs[0] = mkvec(0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0); // idle
    vecs[1] = mkvec(0, 1, 2'b11, 0, 0, 2'b00, 0, 0, 0, 0, 1); // stray leaf in IDLE
    vecs[2] = mkvec(1, 0, 2'b00, 0, 0, 2'b00, 0, 1, 1, 0, 0); // start clears err
    vecs[3] = mkvec(0, 1, 2'b11, 0, 1, 2'b01, 1, 1, 1, 0, 0); // pair0, mask 10
    vecs[4] = mkvec(0, 1, 2'b11, 0, 1, 2'b10, 2, 1, 1, 0, 0); // pair1, mask 01
    vecs[5] = mkvec(0, 0, 2'b00, 1, 0, 2'b00, 2, 1, 1, 0, 0); // ack ignored, bubble
    vecs[6] = mkvec(1, 1, 2'b01, 0, 1, 2'b01, 3, 1, 1, 0, 1); // start in COLLECT
    vecs[7] = mkvec(0, 1, 2'b10, 0, 1, 2'b10, 4, 1, 1, 0, 1); // err stays sticky
    I_frozen_mask = N'('h6);
    for (int i = 0; i < 8; i++) begin
      I_start      = vecs[i].start;
      I_leaf_valid = vecs[i].valid;
      I_leaf_bits  = vecs[i].bits;
      I_out_ack    = vecs[i].ack;
      tick();
      chk($sformatf("vec%0d_flag", i),  32'(O_output_bits_flag), 32'(vecs[i].e_flag));
      if (vecs[i].e_flag)
        chk($sformatf("vec%0d_hard", i), 32'(O_hard_bit_out), 32'(vecs[i].e_hard));
      chk($sformatf("vec%0d_idx", i),   32'(O_pair_idx), 32'(vecs[i].e_idx));
      chk($sformatf("vec%0d_ready", i), 32'(O_leaf_ready), 32'(vecs[i].e_ready));
      chk($sformatf("vec%0d_busy", i),  32'(O_busy), 32'(vecs[i].e_busy));
      chk($sformatf("vec%0d_done", i),  32'(O_frame_done), 32'(vecs[i].e_done));
      chk($sformatf("vec%0d_err", i),   32'(O_err_overrun), 32'(vecs[i].e_err));
    end
    I_start = 1'b0; I_leaf_valid = 1'b0; I_out_ack = 1'b0;
    #2 rst = 1'b0;
    #1 chk_all_zero("table_reset");
    @(negedge clk);
    rst = 1'b1;

    // ---------------- full frame, no mask, back-to-back ----------------
    start_frame('0);
    feed_pairs(0, NP - 1, 0, -1);
    finish_frame();
    ack_frame();

    // ---------------- lower half frozen, all leaves 11 ----------------
    start_frame({{(N/2){1'b0}}, {(N/2){1'b1}}});
    feed_pairs(0, NP - 1, 1, -1);
    chk("half_mask_pair0",   32'(exp_pair[0]), 0);
    chk("half_mask_pair511", 32'(exp_pair[NP - 1]), 3);
    finish_frame();
    ack_frame();

    // ---------------- toggling valid ----------------
    start_frame('0);
    feed_pairs(0, NP - 1, 2, -1);
    finish_frame();

    // ---------------- stray events in DONE ----------------
    I_leaf_valid = 1'b1; I_leaf_bits = 2'b11;
    tick();
    I_leaf_valid = 1'b0;
    chk("done_stray_flag", 32'(O_output_bits_flag), 0);
    chk("done_stray_err",  32'(O_err_overrun), 1);
    chk("done_stray_done", 32'(O_frame_done), 1);
    tick();
    chk("done_err_sticky", 32'(O_err_overrun), 1);
    I_start = 1'b1;
    tick();
    I_start = 1'b0;
    chk("done_start_noack_done",  32'(O_frame_done), 1);
    chk("done_start_noack_busy",  32'(O_busy), 0);
    chk("done_start_noack_err",   32'(O_err_overrun), 1);
    chk("done_start_noack_ready", 32'(O_leaf_ready), 0);
    cur_mask = '0; I_frozen_mask = '0;
    I_start = 1'b1; I_out_ack = 1'b1;
    tick();
    I_start = 1'b0; I_out_ack = 1'b0;
    err_exp = 1'b0; flag_base = flag_cnt;
    chk("startack_ready", 32'(O_leaf_ready), 1);
    chk("startack_busy",  32'(O_busy), 1);
    chk("startack_done",  32'(O_frame_done), 0);
    chk("startack_err",   32'(O_err_overrun), 0);
    chk("startack_idx",   32'(O_pair_idx), 0);

    // ---------------- reset mid-frame after pair 200 ----------------
    feed_pairs(0, 200, 0, -1);
    #2 rst = 1'b0;
    #1 chk_all_zero("midframe_reset");
    @(negedge clk);
    rst = 1'b1;
    start_frame('0);
    feed_pairs(0, NP - 1, 0, -1);
    finish_frame();
    ack_frame();

    // ---------------- start during COLLECT at pair 100 ----------------
    start_frame('0);
    feed_pairs(0, 99, 0, -1);
    // A re-latch on the ignored start would pick up this all-frozen mask.
    I_frozen_mask = '1;
    feed_pairs(100, NP - 1, 0, 100);
    finish_frame();
    ack_frame();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
